rx_frame_checker: RTL
=====================

Name: rx_frame_checker

Overview:
- Consumes the Rx byte stream (`data_tdata`/`data_tvalid`/`data_tlast`/`data_tuser`) directly downstream of the Rx chain.
- Compares each received frame against a locally regenerated PRBS payload.
- Accumulates bit-error, bit, frame and frame-error statistics and tracks link lock with a hysteresis state machine.
- Used in loopback BPSK/QPSK/mixed runs and exposed to the host as BER status registers.

Parameters:
SEED, 8'hFF, LFSR value loaded at each frame start; must be non-zero.
MAX_LEN, 64, maximum bytes per frame before overrun abort.
LOCK_FRAMES, 4, consecutive clean frames required to assert lock.
UNLOCK_FRAMES, 2, consecutive errored frames required to drop lock.

Ports:
clk_32M768  in  1  system clock.
rst_32M768  in  1  reset; synchronous, active-high.
s_tdata  in  8  received byte.
s_tvalid  in  1  byte valid, single-cycle qualifier; no backpressure exists.
s_tlast  in  1  last byte of frame.
s_tuser  in  1  first byte of frame.
clr  in  1  synchronous clear of statistics counters only.
bit_err_cnt  out  32  accumulated payload bit errors.
bit_cnt  out  32  accumulated payload bits checked.
frame_cnt  out  16  frames terminated (ok or errored).
frame_err_cnt  out  16  frames with ≥1 bit error, truncation or overrun.
stray_cnt  out  16  valid beats received outside a frame.
frame_done  out  1  one-cycle pulse when a frame terminates.
frame_ok  out  1  status of the last terminated frame; held until the next termination.
locked  out  1  link lock status.

Behaviour:

Reset:
- All counters 0, `frame_done` 0, `frame_ok` 0, `locked` 0.
- FSM in IDLE, LFSR = SEED, clean/error run counters 0.

Frame FSM:
- IDLE: a beat (`s_tvalid`) with `s_tuser` starts a frame. LFSR loads SEED and the byte is checked against SEED; go to IN_FRAME, or terminate immediately if `s_tlast` is also high (single-byte frame).
- IDLE, beat without `s_tuser`: increment `stray_cnt` and stay in IDLE.
- IN_FRAME, beat without `s_tuser`: check against the current LFSR value and increment the length counter.
- IN_FRAME, `s_tlast` on a beat: terminate and return to IDLE.
- IN_FRAME, `s_tuser` on a beat: abort the current frame as errored (truncated, terminated that cycle). The same beat starts a new frame exactly as from IDLE.
- Overrun: a beat that would be byte MAX_LEN+1 without `s_tlast` terminates the frame as errored. That byte is not checked; go to IDLE, and subsequent beats count as stray until the next `s_tuser`.
- `s_tvalid` low: no state, LFSR or counter change.

Checking:
- Expected byte = LFSR state. After each checked byte the LFSR advances 8 steps.
- One step: feedback = s[7]^s[5]^s[4]^s[3]; s = {s[6:0], feedback}. The 8 steps are unrolled combinationally.
- Errors per byte = popcount(`s_tdata` ^ expected), range 0..8.
- `bit_cnt` += 8 per checked byte; `bit_err_cnt` += popcount.

Latency and termination:
- Statistics update on the clock edge that samples the beat; values are visible the cycle after the beat.
- On termination:
  - `frame_cnt`++.
  - `frame_err_cnt`++ if the frame had any error (including the error on the final byte, truncation or overrun).
  - `frame_ok` = ~error.
  - `frame_done` pulses one cycle, registered the cycle after the terminating beat.
- Abort-then-restart on the same beat yields exactly one `frame_done` pulse for the aborted frame.

Lock FSM (states UNLOCKED, LOCKED), evaluated at each termination:
- Clean frame: clean_run++ and err_run = 0.
- Errored frame: err_run++ and clean_run = 0.
- UNLOCKED→LOCKED when clean_run reaches LOCK_FRAMES.
- LOCKED→UNLOCKED when err_run reaches UNLOCK_FRAMES.
- Run counters saturate at their thresholds.

Width and clear rules:
- All statistics counters saturate at all-ones; no wrap.
- `clr` zeroes the five statistics counters. Any increment in the same cycle is discarded (`clr` wins).
- `clr` does not affect the FSM, LFSR, `locked`, `frame_ok`, `frame_done` or the run counters.

Reset mid-frame: returns everything to reset values immediately. The partial frame is not counted.

Test Plan:
1. Reset, then one clean 16-byte PRBS frame (SEED FF, `tuser` on byte 0, `tlast` on byte 15) → `bit_cnt`=128, `bit_err_cnt`=0, `frame_cnt`=1, `frame_err_cnt`=0, `frame_ok`=1, one `frame_done` pulse the cycle after `tlast`.
2. Four clean frames, then one frame with bit 3 of byte 5 flipped, then one frame with byte 2 = ~expected → `locked` rises after frame 4; `bit_err_cnt`=1 after frame 5, then 9; `locked` falls after frame 6; `frame_err_cnt`=2.
3. Frame restarted by `tuser` at byte 6, then the new frame completes at 10 bytes clean → `frame_cnt`=2, `frame_err_cnt`=1, `bit_cnt`=128, exactly 2 `frame_done` pulses.
4. 70 beats after `tuser` with no `tlast` (MAX_LEN=64) → `frame_err_cnt`=1, `bit_cnt`=512, `stray_cnt`=6.
5. Single beat with `tuser`=`tlast`=1 and data FF → `frame_cnt`=1, `frame_ok`=1, `bit_cnt`=8; data FE → `bit_err_cnt`=1, `frame_ok`=0.
6. `clr` asserted on the same cycle as a mid-frame beat, then the frame completes with 3 further clean bytes → `bit_cnt`=24 and `frame_cnt`=1; `locked` is unchanged by `clr`.

Source files
------------

// File: rtl/rx_frame_checker_if.sv
// Rx byte stream from the receive chain: one beat per valid cycle, no ready.
interface rx_frame_checker_if;
    logic [7:0] s_tdata;
    logic       s_tvalid;
    logic       s_tlast;
    logic       s_tuser;

    modport master (output s_tdata, s_tvalid, s_tlast, s_tuser);
    modport slave  (input  s_tdata, s_tvalid, s_tlast, s_tuser);
endinterface

// File: rtl/rx_frame_checker.sv
// PRBS frame checker: BER/frame statistics plus lock hysteresis on the Rx byte stream.
// Stats visible one cycle after the sampled beat; frame_done one cycle after terminating beat; no backpressure.
module rx_frame_checker #(
    parameter logic [7:0] SEED          = 8'hFF,
    parameter int         MAX_LEN       = 64,
    parameter int         LOCK_FRAMES   = 4,
    parameter int         UNLOCK_FRAMES = 2
) (
    input  logic                 clk_32M768,
    input  logic                 rst_32M768,
    rx_frame_checker_if.slave    s,
    input  logic                 clr,
    output logic [31:0]          bit_err_cnt,
    output logic [31:0]          bit_cnt,
    output logic [15:0]          frame_cnt,
    output logic [15:0]          frame_err_cnt,
    output logic [15:0]          stray_cnt,
    output logic                 frame_done,
    output logic                 frame_ok,
    output logic                 locked
);
    localparam int LEN_W   = $clog2(MAX_LEN + 1);
    localparam int CLEAN_W = $clog2(LOCK_FRAMES + 1);
    localparam int ERR_W   = $clog2(UNLOCK_FRAMES + 1);

    typedef enum logic {IDLE, IN_FRAME}   frame_state_t;
    typedef enum logic {UNLOCKED, LOCKED} lock_state_t;

    frame_state_t       state_q, state_d;
    lock_state_t        lock_q, lock_d;
    logic [7:0]         lfsr_q, lfsr_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ferr_q, ferr_d;
    logic [31:0]        bit_err_q, bit_err_d, bit_q, bit_d;
    logic [15:0]        frame_q, frame_d, frame_err_q, frame_err_d, stray_q, stray_d;
    logic               frame_done_q, frame_done_d, frame_ok_q, frame_ok_d;
    logic [CLEAN_W-1:0] clean_run_q, clean_run_d;
    logic [ERR_W-1:0]   err_run_q, err_run_d;

    logic       check, start, term, term_err, byte_err;
    logic [7:0] expected;
    logic [3:0] nerr;

    function automatic logic [7:0] prbs_adv8(input logic [7:0] v);
        logic [7:0] t;
        t = v;
        for (int i = 0; i < 8; i++) begin
            t = {t[6:0], t[7] ^ t[5] ^ t[4] ^ t[3]};
        end
        return t;
    endfunction

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'd0, v[i]};
        end
        return c;
    endfunction

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [3:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {29'd0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] a);
        return (a == 16'hFFFF) ? a : a + 16'd1;
    endfunction

    always_comb begin
        state_d      = state_q;
        lock_d       = lock_q;
        lfsr_d       = lfsr_q;
        len_d        = len_q;
        ferr_d       = ferr_q;
        bit_err_d    = bit_err_q;
        bit_d        = bit_q;
        frame_d      = frame_q;
        frame_err_d  = frame_err_q;
        stray_d      = stray_q;
        frame_done_d = 1'b0;
        frame_ok_d   = frame_ok_q;
        clean_run_d  = clean_run_q;
        err_run_d    = err_run_q;
        check        = 1'b0;
        start        = 1'b0;
        term         = 1'b0;
        term_err     = 1'b0;
        byte_err     = 1'b0;
        expected     = lfsr_q;
        nerr         = 4'd0;

        if (s.s_tvalid) begin
            if (s.s_tuser) begin
                // A start while in a frame truncates the old one; the beat still opens a new frame.
                if (state_q == IN_FRAME) begin
                    term     = 1'b1;
                    term_err = 1'b1;
                end
                start    = 1'b1;
                check    = 1'b1;
                expected = SEED;
            end else if (state_q == IDLE) begin
                stray_d = sat_inc16(stray_q);
            end else if (len_q == LEN_W'(MAX_LEN) && !s.s_tlast) begin
                term     = 1'b1;
                term_err = 1'b1;
                state_d  = IDLE;
            end else begin
                check = 1'b1;
            end
        end

        if (check) begin
            nerr      = popcount8(s.s_tdata ^ expected);
            byte_err  = (nerr != 4'd0);
            bit_d     = sat_add32(bit_q, 4'd8);
            bit_err_d = sat_add32(bit_err_q, nerr);
            lfsr_d    = prbs_adv8(expected);
            if (start) begin
                len_d   = LEN_W'(1);
                ferr_d  = byte_err;
                state_d = IN_FRAME;
            end else begin
                len_d  = len_q + LEN_W'(1);
                ferr_d = ferr_q | byte_err;
            end
            // With a same-beat abort, only the aborted frame is reported and the 1-byte frame is dropped.
            if (s.s_tlast) begin
                state_d = IDLE;
                if (!term) begin
                    term     = 1'b1;
                    term_err = ferr_d;
                end
            end
        end

        if (term) begin
            frame_d      = sat_inc16(frame_q);
            frame_done_d = 1'b1;
            frame_ok_d   = ~term_err;
            if (term_err) begin
                frame_err_d = sat_inc16(frame_err_q);
                clean_run_d = '0;
                err_run_d   = (err_run_q == ERR_W'(UNLOCK_FRAMES)) ? err_run_q : err_run_q + ERR_W'(1);
            end else begin
                err_run_d   = '0;
                clean_run_d = (clean_run_q == CLEAN_W'(LOCK_FRAMES)) ? clean_run_q
                                                                      : clean_run_q + CLEAN_W'(1);
            end
            if (lock_q == UNLOCKED && clean_run_d == CLEAN_W'(LOCK_FRAMES)) begin
                lock_d = LOCKED;
            end else if (lock_q == LOCKED && err_run_d == ERR_W'(UNLOCK_FRAMES)) begin
                lock_d = UNLOCKED;
            end
        end

        if (clr) begin
            bit_err_d   = '0;
            bit_d       = '0;
            frame_d     = '0;
            frame_err_d = '0;
            stray_d     = '0;
        end
    end

    always_ff @(posedge clk_32M768) begin
        if (rst_32M768) begin
            state_q      <= IDLE;
            lock_q       <= UNLOCKED;
            lfsr_q       <= SEED;
            len_q        <= '0;
            ferr_q       <= 1'b0;
            bit_err_q    <= '0;
            bit_q        <= '0;
            frame_q      <= '0;
            frame_err_q  <= '0;
            stray_q      <= '0;
            frame_done_q <= 1'b0;
            frame_ok_q   <= 1'b0;
            clean_run_q  <= '0;
            err_run_q    <= '0;
        end else begin
            state_q      <= state_d;
            lock_q       <= lock_d;
            lfsr_q       <= lfsr_d;
            len_q        <= len_d;
            ferr_q       <= ferr_d;
            bit_err_q    <= bit_err_d;
            bit_q        <= bit_d;
            frame_q      <= frame_d;
            frame_err_q  <= frame_err_d;
            stray_q      <= stray_d;
            frame_done_q <= frame_done_d;
            frame_ok_q   <= frame_ok_d;
            clean_run_q  <= clean_run_d;
            err_run_q    <= err_run_d;
        end
    end

    assign bit_err_cnt   = bit_err_q;
    assign bit_cnt       = bit_q;
    assign frame_cnt     = frame_q;
    assign frame_err_cnt = frame_err_q;
    assign stray_cnt     = stray_q;
    assign frame_done    = frame_done_q;
    assign frame_ok      = frame_ok_q;
    assign locked        = (lock_q == LOCKED);
endmodule
